// File: rtl/posit_pkg.sv
// Shared posit definitions: default geometry, derived widths and special-value patterns.
package posit_pkg;

    localparam int unsigned POSIT_N  = 8;
    localparam int unsigned POSIT_ES = 1;
    localparam int unsigned POSIT_FW = 8;
    localparam int unsigned MAX_N    = 64;

    // Signed scale width covering every regime/exponent combination of an n-bit posit
    function automatic int unsigned scale_width(input int unsigned n, input int unsigned es);
        return $clog2(n) + es + 2;
    endfunction

    function automatic logic [MAX_N-1:0] nar_word(input int unsigned n);
        return MAX_N'(1) << (n - 1);
    endfunction

    function automatic logic [MAX_N-1:0] zero_word();
        return '0;
    endfunction

    function automatic logic [MAX_N-1:0] maxpos_mag(input int unsigned n);
        return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
    endfunction

    function automatic logic [MAX_N-1:0] minpos_mag();
        return MAX_N'(1);
    endfunction

endpackage

// File: rtl/posit_encoder_if.sv
// Valid/ready operand and result bundle for the posit encoder.
interface posit_encoder_if
    import posit_pkg::*;
#(
    parameter int unsigned N  = POSIT_N,
    parameter int unsigned ES = POSIT_ES,
    parameter int unsigned FW = POSIT_FW
);
    localparam int unsigned SW = scale_width(N, ES);

    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic          in_zero;
    logic          in_nar;
    logic [SW-1:0] in_scale;
    logic [FW-1:0] in_frac;
    logic          in_sticky;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_posit;

    modport master (
        output in_valid, in_sign, in_zero, in_nar, in_scale, in_frac, in_sticky, out_ready,
        input  in_ready, out_valid, out_posit
    );

    modport slave (
        input  in_valid, in_sign, in_zero, in_nar, in_scale, in_frac, in_sticky, out_ready,
        output in_ready, out_valid, out_posit
    );

endinterface

// File: rtl/posit_round.sv
// Stage-2 combinational pack: round-to-nearest-even, saturation clamp, sign and specials.
module posit_round
    import posit_pkg::*;
#(
    parameter int unsigned N = POSIT_N
) (
    input  logic [N-2:0] mag,
    input  logic         guard,
    input  logic         sticky,
    input  logic         sign,
    input  logic         zero,
    input  logic         nar,
    input  logic         sat_max,
    input  logic         sat_min,
    output logic [N-1:0] posit_c
);

    localparam int unsigned MW = N - 1;

    logic          round_up_c;
    logic [MW:0]   sum_c;
    logic [MW-1:0] mag_c;

    always_comb begin
        round_up_c = guard & (sticky | mag[0]);
        sum_c      = {1'b0, mag} + (MW+1)'(round_up_c);
        // A carry out of the magnitude would cross into NaR; pin it at maxpos
        mag_c      = sum_c[MW] ? MW'(maxpos_mag(N)) : sum_c[MW-1:0];
        if (sat_max) begin
            mag_c = MW'(maxpos_mag(N));
        end else if (sat_min) begin
            mag_c = MW'(minpos_mag());
        end
        if (mag_c == '0) begin
            mag_c = MW'(minpos_mag());
        end

        posit_c = sign ? ((~{1'b0, mag_c}) + N'(1)) : {1'b0, mag_c};
        if (nar) begin
            posit_c = N'(nar_word(N));
        end else if (zero) begin
            posit_c = N'(zero_word());
        end
    end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage valid/ready posit packer: stage 1 builds the regime string, stage 2 rounds and packs.
module posit_encoder
    import posit_pkg::*;
#(
    parameter int unsigned N  = POSIT_N,
    parameter int unsigned ES = POSIT_ES,
    parameter int unsigned FW = POSIT_FW
) (
    input logic             clk,
    input logic             rst,
    posit_encoder_if.slave  bus
);

    localparam int unsigned SW   = scale_width(N, ES);
    localparam int unsigned MW   = N - 1;
    localparam int unsigned BW   = ES + FW;
    localparam int unsigned TW   = N + 1 + BW;
    localparam int unsigned GB   = BW + 1;
    localparam int          KMAX = int'(N) - 2;

    typedef struct packed {
        logic [MW-1:0] mag;
        logic          guard;
        logic          sticky;
        logic          sign;
        logic          zero;
        logic          nar;
        logic          sat_max;
        logic          sat_min;
    } s1_t;

    logic signed [SW-1:0] k_c;
    logic [BW-1:0]        body_c;
    logic [TW-1:0]        tmpl_c;
    logic [TW-1:0]        shifted_c;
    logic                 neg_k_c;
    logic                 sat_max_c;
    logic                 sat_min_c;
    int                   shamt_c;

    logic                 s2_adv_c;
    logic                 in_ready_c;
    logic [N-1:0]         posit_c;

    logic                 s1_valid_q, s1_valid_d;
    s1_t                  s1_q, s1_d;
    logic                 out_valid_q, out_valid_d;
    logic [N-1:0]         out_posit_q, out_posit_d;

    // Regime template is N fill bits, terminator, then exponent and fraction; the left
    // shift trims the fill run to the regime length so the magnitude sits at the top.
    always_comb begin
        k_c       = $signed(bus.in_scale) >>> ES;
        body_c    = BW'({bus.in_scale, bus.in_frac});
        neg_k_c   = k_c[SW-1];
        sat_max_c = int'(k_c) >= KMAX;
        sat_min_c = int'(k_c) < -KMAX;
        tmpl_c    = neg_k_c ? {{N{1'b0}}, 1'b1, body_c} : {{N{1'b1}}, 1'b0, body_c};
        if (sat_max_c || sat_min_c) begin
            shamt_c = 0;
        end else if (neg_k_c) begin
            shamt_c = int'(N) + int'(k_c);
        end else begin
            shamt_c = int'(N) - 1 - int'(k_c);
        end
        shifted_c = tmpl_c << shamt_c;
    end

    // Pipeline advance and stage loads
    always_comb begin
        s2_adv_c    = !out_valid_q || bus.out_ready;
        in_ready_c  = !s1_valid_q || s2_adv_c;
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_posit_d = out_posit_q;

        if (in_ready_c) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d = '{mag:     shifted_c[TW-1 -: MW],
                         guard:   shifted_c[GB],
                         sticky:  (|shifted_c[BW:0]) | bus.in_sticky,
                         sign:    bus.in_sign,
                         zero:    bus.in_zero,
                         nar:     bus.in_nar,
                         sat_max: sat_max_c,
                         sat_min: sat_min_c};
            end
        end

        if (s2_adv_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_posit_d = posit_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_posit_q <= out_posit_d;
        end
    end

    posit_round #(.N(N)) u_round (
        .mag     (s1_q.mag),
        .guard   (s1_q.guard),
        .sticky  (s1_q.sticky),
        .sign    (s1_q.sign),
        .zero    (s1_q.zero),
        .nar     (s1_q.nar),
        .sat_max (s1_q.sat_max),
        .sat_min (s1_q.sat_min),
        .posit_c (posit_c)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_posit = out_posit_q;

endmodule
